counter_host: RTL and testbench

COUNTER_HOST -- requirements
Module: counter_host

---
 rtl/counter_pkg.sv | 39 +++
 rtl/counter_read_collector.sv | 87 ++++++++
 rtl/counter_host.sv | 150 +++++++++++++++
 tb/tb_counter_host.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: encodings shared by the counter bank host.
//   op_e    : host request opcodes (req_op)
//   cmd_e   : bank command encoding (command_out)
//   state_e : counter_host FSM states
//   op2cmd  : maps an accepted request opcode onto its bank command
package counter_pkg;

  typedef enum logic [1:0] {
    OP_INC     = 2'b00,
    OP_ALLOC   = 2'b01,
    OP_DEALLOC = 2'b10,
    OP_READ    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    CMD_IDLE    = 3'b000,
    CMD_INC     = 3'b001,
    CMD_ALLOC   = 3'b010,
    CMD_DEALLOC = 3'b011,
    CMD_READ    = 3'b101
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_READ,
    S_RESP
  } state_e;

  function automatic cmd_e op2cmd(op_e op);
    case (op)
      OP_INC:     return CMD_INC;
      OP_ALLOC:   return CMD_ALLOC;
      OP_DEALLOC: return CMD_DEALLOC;
      default:    return CMD_READ;
    endcase
  endfunction

endpackage

// File: rtl/counter_read_collector.sv
// counter_read_collector: deserializes bank read beats into one wide value.
//   clk, rst  : clock, async active-high reset
//   start     : clears the collector (host is issuing a new command)
//   active    : host is in its READ state; beats outside it are ignored
//   base      : id of the counter being read (first subcounter index)
//   rdata/rvalid/rlast : bank beat stream
//   done      : this cycle terminates the read
//   timeout   : read aborted for lack of a first beat (COUNTER_HOST_TIMEOUT_EN)
//   data_nxt/len_nxt : packed value and beat count including this cycle's beat
module counter_read_collector
  import counter_pkg::*;
#(
  parameter  int N  = 10,
  parameter  int G  = 4,
  localparam int W  = N * G,
  localparam int IW = $clog2(N),
  localparam int SW = IW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          active,
  input  logic [IW-1:0] base,
  input  logic [G-1:0]  rdata,
  input  logic          rvalid,
  input  logic          rlast,
  output logic          done,
  output logic          timeout,
  output logic [W-1:0]  data_nxt,
  output logic [SW-1:0] len_nxt
);

  logic [W-1:0]  data_q;
  logic [SW-1:0] cnt_q;
  logic          beat;
  logic          at_end;

  assign beat = active && rvalid;

  // Beat k lands in slice k; slices not yet written stay zero from start.
  always_comb begin
    data_nxt = data_q;
    for (int k = 0; k < N; k++)
      if (beat && cnt_q == SW'(k)) data_nxt[k*G +: G] = rdata;
    len_nxt = cnt_q + SW'(beat);
  end

  // The counter cannot extend past subcounter N-1, so the beat that reaches
  // it is the last one even when the bank does not flag it.
  assign at_end = (int'(base) + int'(len_nxt)) >= N;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (beat) begin
      data_q <= data_nxt;
      cnt_q  <= len_nxt;
    end
  end

`ifdef COUNTER_HOST_TIMEOUT_EN
  // Counts READ cycles spent waiting for the first beat; the ninth empty
  // cycle gives up.
  logic [3:0] wait_q;
  logic       waiting;

  assign waiting = active && cnt_q == '0 && !rvalid;
  assign timeout = waiting && wait_q == 4'd8;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         wait_q <= '0;
    else if (start)                  wait_q <= '0;
    else if (waiting && !timeout)    wait_q <= wait_q + 4'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  // A gap after the stream has started also ends it.
  assign done = active && ((beat && (rlast || at_end)) ||
                           (!rvalid && cnt_q != '0) || timeout);

endmodule

// File: rtl/counter_host.sv
// counter_host: request/response front end for a bank of N G-bit subcounters.
// Accepts inc/alloc/dealloc/read requests, issues one registered bank
// command per request, collects read beats and returns a single response.
//   clk, rst                        : clock, async active-high reset
//   req_valid/req_ready/req_op/req_id/req_size : request channel
//   command_out/id_out/size_out     : bank command (000 = idle)
//   alloc_id_in/alloc_valid_in      : bank allocation result
//   rdata_in/rvalid_in/rlast_in     : bank read beat stream
//   rsp_valid/rsp_ready/rsp_ok/rsp_data/rsp_len : response channel
// Build option: COUNTER_HOST_TIMEOUT_EN aborts a read that sees no beat.
module counter_host
  import counter_pkg::*;
#(
  parameter  int N  = 10,
  parameter  int G  = 4,
  localparam int W  = N * G,
  localparam int IW = $clog2(N),
  localparam int SW = IW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [IW-1:0] req_id,
  input  logic [SW-1:0] req_size,
  output logic [2:0]    command_out,
  output logic [IW-1:0] id_out,
  output logic [SW-1:0] size_out,
  input  logic [SW-1:0] alloc_id_in,
  input  logic          alloc_valid_in,
  input  logic [G-1:0]  rdata_in,
  input  logic          rvalid_in,
  input  logic          rlast_in,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_ok,
  output logic [W-1:0]  rsp_data,
  output logic [SW-1:0] rsp_len
);

  state_e        state;
  op_e           op_q;
  op_e           req_op_e;
  logic          accept;
  logic          bad_req;
  logic          col_done;
  logic          col_timeout;
  logic [W-1:0]  col_data;
  logic [SW-1:0] col_len;

  assign req_op_e = op_e'(req_op);
  assign accept   = req_valid && req_ready;
  assign bad_req  = (int'(req_id) >= N) ||
                    (req_op_e == OP_ALLOC && (req_size == '0 || int'(req_size) > N));

  counter_read_collector #(.N(N), .G(G)) u_collect (
    .clk      (clk),
    .rst      (rst),
    .start    (state == S_ISSUE),
    .active   (state == S_READ),
    .base     (id_out),
    .rdata    (rdata_in),
    .rvalid   (rvalid_in),
    .rlast    (rlast_in),
    .done     (col_done),
    .timeout  (col_timeout),
    .data_nxt (col_data),
    .len_nxt  (col_len)
  );

  // Every path from a command back to the next one passes RESP and IDLE with
  // command_out at idle, so bank commands are always separated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= OP_INC;
      req_ready   <= 1'b0;
      command_out <= CMD_IDLE;
      id_out      <= '0;
      size_out    <= '0;
      rsp_valid   <= 1'b0;
      rsp_ok      <= 1'b0;
      rsp_data    <= '0;
      rsp_len     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            op_q      <= req_op_e;
            if (bad_req) begin
              // Rejected: answer straight away, the bank never sees it.
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_ok    <= 1'b0;
              rsp_data  <= '0;
              rsp_len   <= '0;
            end else begin
              state       <= S_ISSUE;
              command_out <= op2cmd(req_op_e);
              id_out      <= req_id;
              size_out    <= (req_op_e == OP_ALLOC) ? req_size : '0;
            end
          end
        end
        S_ISSUE: begin
          if (op_q == OP_READ) begin
            // Read command stays on the bus until the stream ends.
            state <= S_READ;
          end else begin
            state       <= S_RESP;
            command_out <= CMD_IDLE;
            id_out      <= '0;
            size_out    <= '0;
            rsp_valid   <= 1'b1;
            rsp_len     <= '0;
            if (op_q == OP_ALLOC) begin
              rsp_ok   <= alloc_valid_in;
              rsp_data <= W'(alloc_id_in);
            end else begin
              rsp_ok   <= 1'b1;
              rsp_data <= '0;
            end
          end
        end
        S_READ: begin
          if (col_done) begin
            state       <= S_RESP;
            command_out <= CMD_IDLE;
            id_out      <= '0;
            rsp_valid   <= 1'b1;
            rsp_ok      <= !col_timeout;
            rsp_data    <= col_timeout ? '0 : col_data;
            rsp_len     <= col_timeout ? '0 : col_len;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_host.sv
module tb_counter_host;
  localparam int N  = 10;
  localparam int G  = 4;
  localparam int W  = N * G;
  localparam int IW = $clog2(N);
  localparam int SW = IW + 1;

  localparam logic [1:0] OPI = 2'b00, OPA = 2'b01, OPD = 2'b10, OPR = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [IW-1:0] req_id = '0;
  logic [SW-1:0] req_size = '0;
  logic [2:0]    command_out;
  logic [IW-1:0] id_out;
  logic [SW-1:0] size_out;
  logic [SW-1:0] alloc_id_in = '0;
  logic          alloc_valid_in = 1'b0;
  logic [G-1:0]  rdata_in = '0;
  logic          rvalid_in = 1'b0;
  logic          rlast_in = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_ok;
  logic [W-1:0]  rsp_data;
  logic [SW-1:0] rsp_len;

  counter_host #(.N(N), .G(G)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_id(req_id), .req_size(req_size),
    .command_out(command_out), .id_out(id_out), .size_out(size_out),
    .alloc_id_in(alloc_id_in), .alloc_valid_in(alloc_valid_in),
    .rdata_in(rdata_in), .rvalid_in(rvalid_in), .rlast_in(rlast_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ok(rsp_ok),
    .rsp_data(rsp_data), .rsp_len(rsp_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ok;
    logic [W-1:0]  data;
    logic [SW-1:0] len;
  } rsp_t;

  rsp_t         exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           bp_hold  = 0;
  logic [G-1:0] beat_buf[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic push_exp(input logic ok, input logic [W-1:0] data, input logic [SW-1:0] len);
    rsp_t e;
    e.ok = ok; e.data = data; e.len = len;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: owns rsp_ready; compares at each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (bp_hold > 0 && rsp_valid) begin
        rsp_ready = 1'b0;
        bp_hold--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("rsp_ok", 64'(rsp_ok), 64'(e.ok));
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          chk("rsp_len", 64'(rsp_len), 64'(e.len));
        end
      end
    end
  end

  // Offers a request; returns at the negedge of the cycle after acceptance.
  task automatic issue(input logic [1:0] op, input int id, input int size);
    int waited = 0;
    do begin
      @(negedge clk);
      waited++;
      if (waited > 200) begin
        chk("req_ready_wait", 64'(req_ready), 64'd1);
        finish_test();
      end
    end while (!req_ready);
    req_valid = 1'b1;
    req_op    = op;
    req_id    = IW'(id);
    req_size  = SW'(size);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_id    = IW'($urandom);
    req_size  = SW'($urandom);
  endtask

  // Bank side of a read, entered in the ISSUE-cycle negedge.
  task automatic bank_read(input int nb, input bit use_last, input bit at_end,
                           input bit extra, input int gap, input bit junk);
    bit term_on_beat = use_last || at_end;
    chk("rd_cmd_issue", 64'(command_out), 64'h5);
    if (junk) begin
      rvalid_in = 1'b1; rdata_in = G'($urandom); rlast_in = 1'b1;
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      rvalid_in = 1'b0; rlast_in = 1'b0;
    end
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      if (k > 0) chk("rd_cmd_hold", 64'(command_out), 64'h5);
      rvalid_in = 1'b1;
      rdata_in  = beat_buf[k];
      rlast_in  = use_last && (k == nb - 1);
    end
    @(negedge clk);
    rvalid_in = extra;
    rdata_in  = G'($urandom);
    rlast_in  = 1'b0;
    if (term_on_beat) begin
      chk("rd_latency", 64'(rsp_valid), 64'd1);
      chk("rd_cmd_off", 64'(command_out), 64'd0);
    end else begin
      chk("rd_cmd_still_on", 64'(command_out), 64'h5);
      @(negedge clk);
      chk("rd_gap_end", 64'(rsp_valid), 64'd1);
      chk("rd_gap_cmd_off", 64'(command_out), 64'd0);
    end
    if (extra) @(negedge clk);
    rvalid_in = 1'b0;
    rlast_in  = 1'b0;
  endtask

  task automatic do_read(input int id, input int nb, input bit use_last, input bit extra,
                         input int gap, input bit junk);
    logic [W-1:0] exp_data = '0;
    for (int k = 0; k < nb; k++) exp_data = exp_data | (W'(beat_buf[k]) << (k * G));
    push_exp(1'b1, exp_data, SW'(nb));
    issue(OPR, id, 0);
    chk("rd_id_out", 64'(id_out), 64'(id));
    bank_read(nb, use_last, (id + nb) == N, extra, gap, junk);
  endtask

  task automatic run_random(input int count);
    for (int t = 0; t < count; t++) begin
      logic [1:0] op = 2'($urandom_range(0, 3));
      int id   = ($urandom_range(0, 7) == 0) ? $urandom_range(N, (1 << IW) - 1)
                                             : $urandom_range(0, N - 1);
      int size = $urandom_range(0, N + 2);
      bit bad  = (id >= N) || (op == OPA && (size == 0 || size > N));
      if (bad) begin
        push_exp(1'b0, '0, '0);
        issue(op, id, size);
        chk("rej_no_cmd", 64'(command_out), 64'd0);
      end else if (op == OPR) begin
        int  nmax = N - id;
        int  nb   = $urandom_range(1, nmax);
        bit  ul   = $urandom_range(0, 1);
        bit  ex   = (ul || nb == nmax) && ($urandom_range(0, 1) == 1);
        for (int k = 0; k < nb; k++) beat_buf[k] = G'($urandom);
        do_read(id, nb, ul, ex, $urandom_range(0, 3), $urandom_range(0, 1));
      end else if (op == OPA) begin
        alloc_id_in    = SW'($urandom);
        alloc_valid_in = $urandom_range(0, 1);
        push_exp(alloc_valid_in, W'(alloc_id_in), '0);
        issue(op, id, size);
        chk("alloc_cmd", 64'(command_out), 64'h2);
        chk("alloc_size", 64'(size_out), 64'(size));
      end else begin
        push_exp(1'b1, '0, '0);
        issue(op, id, size);
        chk("incdec_cmd", 64'(command_out), (op == OPI) ? 64'h1 : 64'h3);
        chk("incdec_id", 64'(id_out), 64'(id));
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_cmd", 64'(command_out), 64'd0);
    chk("rst_id_out", 64'(id_out), 64'd0);
    chk("rst_size_out", 64'(size_out), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_ok", 64'(rsp_ok), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_len", 64'(rsp_len), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    // Allocate size 3, bank returns id 2
    alloc_id_in = SW'(2); alloc_valid_in = 1'b1;
    push_exp(1'b1, W'(2), '0);
    issue(OPA, 0, 3);
    chk("alloc_cmd_010", 64'(command_out), 64'h2);
    chk("alloc_size_3", 64'(size_out), 64'd3);
    chk("alloc_no_rsp_yet", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("alloc_cmd_one_cycle", 64'(command_out), 64'd0);
    chk("alloc_latency", 64'(rsp_valid), 64'd1);

    // Read with last: id 2, beats 5,A,3
    beat_buf[0] = 4'h5; beat_buf[1] = 4'hA; beat_buf[2] = 4'h3;
    do_read(2, 3, 1'b1, 1'b0, 0, 1'b0);

    // Read ending at subcounter N-1 with no last; bank keeps rvalid high after
    beat_buf[0] = 4'hF; beat_buf[1] = 4'h1; beat_buf[2] = 4'h2;
    do_read(7, 3, 1'b0, 1'b1, 0, 1'b0);

    // Rejection of id 12 under 5 cycles of backpressure
    bp_hold = 5;
    push_exp(1'b0, '0, '0);
    issue(OPI, 12, 0);
    chk("rej_cmd_idle", 64'(command_out), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_ok", 64'(rsp_ok), 64'd0);
      chk("bp_rsp_data", 64'(rsp_data), 64'd0);
      chk("bp_rsp_len", 64'(rsp_len), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      if (i < 4) @(negedge clk);
    end

    // Read stopped by a gap after beats
    beat_buf[0] = 4'h6; beat_buf[1] = 4'h9;
    do_read(1, 2, 1'b0, 1'b0, 2, 1'b1);

    run_random(60);

    // Reset during beat 2 of a read: nothing may be answered
    issue(OPR, 0, 0);
    chk("mr_cmd", 64'(command_out), 64'h5);
    @(negedge clk); rvalid_in = 1'b1; rdata_in = 4'h1;
    @(negedge clk); rdata_in = 4'h2;
    @(negedge clk); rdata_in = 4'h3; rst = 1'b1;
    #1;
    chk("mr_cmd_off", 64'(command_out), 64'd0);
    chk("mr_no_rsp", 64'(rsp_valid), 64'd0);
    chk("mr_ready_low", 64'(req_ready), 64'd0);
    @(negedge clk); rvalid_in = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("mr_ready_after", 64'(req_ready), 64'd1);
    chk("mr_cmd_idle", 64'(command_out), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mr_still_no_rsp", 64'(rsp_valid), 64'd0);
    end

`ifdef COUNTER_HOST_TIMEOUT_EN
    // No beat at all: aborted 9 cycles after entering READ
    push_exp(1'b0, '0, '0);
    issue(OPR, 0, 0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("to_wait", 64'(rsp_valid), 64'd0);
    end
    @(negedge clk);
    chk("to_rsp", 64'(rsp_valid), 64'd1);
`endif

    run_random(20);

    // Drain the scoreboard
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    repeat (5) @(negedge clk);
    finish_test();
  end

endmodule
